// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flip-flop
// process the operands LSB-first, then the result waits for downstream.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic k_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign k_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_k;

   full_adder u_fa (
      .a_i (a_sh_q[0]),
      .b_i (b_sh_q[0]),
      .c_i (c_q),
      .s_o (fa_s),
      .k_o (fa_k)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      c_d     = c_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               c_d     = cin;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d  = {fa_s, sum_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            c_d    = fa_k;
            // Counter holds on the last bit so it never wraps.
            if (cnt_q == LAST) begin
               cout_d  = fa_k;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random operand sets checked against a
// cycle-level reference model of the accept/compute/hold behaviour.

module tb_serial_adder;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted operand set occupies the block for WIDTH
   // cycles, then the result is offered until out_ready is seen.
   int           m_busy = 0;
   bit           m_done = 1'b0;
   logic [WIDTH:0] m_pend = '0;
   logic [WIDTH:0] m_res  = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
      end else if (m_done) begin
         if (out_ready) m_done <= 1'b0;
      end else if (m_busy != 0) begin
         m_busy <= m_busy - 1;
         if (m_busy == 1) begin
            m_done <= 1'b1;
            m_res  <= m_pend;
         end
      end else if (in_valid) begin
         m_busy <= WIDTH;
         m_pend <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("in_ready", 32'(in_ready), 32'((m_busy == 0) && !m_done));
         check("out_valid", 32'(out_valid), 32'(m_done));
         if (m_busy == 0) begin
            check("sum", 32'(sum), 32'(m_res[WIDTH-1:0]));
            check("cout", 32'(cout), 32'(m_res[WIDTH]));
         end
      end
   end

   // Present operands at a negedge, hold until taken, drop at the next negedge.
   task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
      int n;
      in_valid = 1'b1;
      a = av;
      b = bv;
      cin = cv;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input logic [WIDTH-1:0] es, input logic ec);
      int n;
      n = 0;
      while (!out_valid && n <= WIDTH + 4) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(WIDTH));
      check("res_sum", 32'(sum), 32'(es));
      check("res_cout", 32'(cout), 32'(ec));
      check("model_res", 32'(m_res), 32'({ec, es}));
   endtask

   task automatic release_res(input int stall);
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      logic [WIDTH:0]   rs;

      #2 rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      send(8'h5A, 8'h3C, 1'b0); wait_valid(8'h96, 1'b0); release_res(0);
      send(8'hFF, 8'h01, 1'b0); wait_valid(8'h00, 1'b1); release_res(1);
      send(8'hFF, 8'hFF, 1'b1); wait_valid(8'hFF, 1'b1); release_res(0);
      send(8'h00, 8'h00, 1'b1); wait_valid(8'h01, 1'b0); release_res(2);

      // Back-pressure with new operands waiting upstream.
      send(8'h12, 8'h34, 1'b0); wait_valid(8'h46, 1'b0);
      in_valid = 1'b1; a = 8'hAA; b = 8'h11; cin = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_sum", 32'(sum), 32'h46);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("exit_in_ready", 32'(in_ready), 32'd1);
      check("exit_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("late_accept", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      wait_valid(8'hBC, 1'b0); release_res(0);

      // Abort mid-computation.
      send(8'h77, 8'h88, 1'b1);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_sum", 32'(sum), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(8'h10, 8'h20, 1'b0); wait_valid(8'h30, 1'b0); release_res(0);

      for (int i = 0; i < 1000; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
         rs = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(ra, rb, rc);
         wait_valid(rs[WIDTH-1:0], rs[WIDTH]);
         release_res($urandom_range(0, 3));
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
